// File: rtl/alu_pkg.sv
// Shared definitions for the UART/ALU sequencer.
//   - ALU opcode values understood by the top-level ALU
//   - FSM state type used by alu_uart_ctrl
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// Bus between the sequencer and its UART RX / UART TX / ALU neighbours.
//   master : sequencer side (receives rx/tx/alu inputs, drives operands,
//            opcode, tx request and status pulses)
//   slave  : environment side (UART RX/TX and ALU)
// Signals:
//   i_rx_done/i_rx_data  new received byte (1-cycle pulse + data)
//   i_tx_done            UART TX finished current byte
//   i_alu_result         combinational ALU output
//   o_dato_A/o_dato_B    ALU operands
//   o_operacion          ALU opcode
//   o_tx_start/o_tx_data TX request pulse + result byte
//   o_busy/o_drop/o_timeout  status
interface alu_uart_ctrl_if #(
  parameter int unsigned N_BITS = 8,
  parameter int unsigned N_OP   = 6
) ();

  logic              i_rx_done;
  logic [N_BITS-1:0] i_rx_data;
  logic              i_tx_done;
  logic [N_BITS-1:0] i_alu_result;
  logic [N_BITS-1:0] o_dato_A;
  logic [N_BITS-1:0] o_dato_B;
  logic [N_OP-1:0]   o_operacion;
  logic              o_tx_start;
  logic [N_BITS-1:0] o_tx_data;
  logic              o_busy;
  logic              o_drop;
  logic              o_timeout;

  modport master (
    input  i_rx_done, i_rx_data, i_tx_done, i_alu_result,
    output o_dato_A, o_dato_B, o_operacion, o_tx_start, o_tx_data,
           o_busy, o_drop, o_timeout
  );

  modport slave (
    output i_rx_done, i_rx_data, i_tx_done, i_alu_result,
    input  o_dato_A, o_dato_B, o_operacion, o_tx_start, o_tx_data,
           o_busy, o_drop, o_timeout
  );

endinterface

// File: rtl/alu_uart_ctrl_byte_timeout.sv
// Inter-byte idle counter.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : clear (a byte was accepted); has priority over expiry
//   i_en           : count this cycle (waiting for the next byte of a frame)
//   o_expire       : combinational, high in the LIMIT-th consecutive enabled cycle
// LIMIT = 0 disables expiry entirely.
module byte_timeout #(
  parameter int unsigned LIMIT = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] C_LAST = (LIMIT == 0) ? '0 : W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  // Expiry fires in the cycle whose completion would make the count reach LIMIT,
  // so the FSM leaves the wait state on the same edge the counter would hit it.
  assign o_expire = (LIMIT != 0) && i_en && !i_clr && (r_cnt == C_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_expire) begin
      r_cnt <= '0;
    end else if (i_en && (LIMIT != 0) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_uart_ctrl.sv
// Sequencer between UART RX/TX and the combinational ALU.
// Collects operand A, operand B and opcode bytes, lets the ALU settle for one
// cycle, registers the result and requests transmission, then waits for TX.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (master)   : rx/tx handshakes, ALU operands/opcode/result, status pulses
module alu_uart_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned N_BITS      = 8,
  parameter int unsigned N_OP        = 6,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  alu_uart_ctrl_if.master       bus
);

  state_t r_state, w_state_nxt;

  logic              w_wait;
  logic              w_accept;
  logic              w_drop;
  logic              w_expire;
  logic [N_BITS-1:0] r_dato_a;
  logic [N_BITS-1:0] r_dato_b;
  logic [N_OP-1:0]   r_operacion;
  logic [N_BITS-1:0] r_tx_data;
  logic              r_drop;
  logic              r_timeout;

  // Kept outside the FSM process so the timeout path has no apparent loop.
  assign w_wait   = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
  assign w_accept = bus.i_rx_done && ((r_state == ST_IDLE) || w_wait);

  byte_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_accept),
    .i_en     (w_wait),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drop      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.i_rx_done) w_state_nxt = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (bus.i_rx_done)  w_state_nxt = ST_WAIT_OP;
        else if (w_expire)  w_state_nxt = ST_IDLE;
      end
      ST_WAIT_OP: begin
        if (bus.i_rx_done)  w_state_nxt = ST_EXEC;
        else if (w_expire)  w_state_nxt = ST_IDLE;
      end
      ST_EXEC: begin
        w_drop      = bus.i_rx_done;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        w_drop      = bus.i_rx_done;
        w_state_nxt = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        w_drop = bus.i_rx_done;
        if (bus.i_tx_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dato_a    <= '0;
      r_dato_b    <= '0;
      r_operacion <= '0;
      r_tx_data   <= '0;
      r_drop      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_accept) begin
        case (r_state)
          ST_IDLE:    r_dato_a    <= bus.i_rx_data;
          ST_WAIT_B:  r_dato_b    <= bus.i_rx_data;
          ST_WAIT_OP: r_operacion <= bus.i_rx_data[N_OP-1:0];
          default:    ;
        endcase
      end
      if (r_state == ST_EXEC) r_tx_data <= bus.i_alu_result;
      r_drop    <= w_drop;
      r_timeout <= w_expire;
    end
  end

  assign bus.o_dato_A    = r_dato_a;
  assign bus.o_dato_B    = r_dato_b;
  assign bus.o_operacion = r_operacion;
  assign bus.o_tx_data   = r_tx_data;
  assign bus.o_tx_start  = (r_state == ST_SEND);
  assign bus.o_busy      = (r_state != ST_IDLE);
  assign bus.o_drop      = r_drop;
  assign bus.o_timeout   = r_timeout;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Self-checking bench for alu_uart_ctrl: directed frames from the datasheet
// examples plus randomized frames, checked against a behavioural frame model.
module tb_alu_uart_ctrl;
  import alu_pkg::*;

  logic clk;
  logic rst_n;

  alu_uart_ctrl_if #(.N_BITS(8), .N_OP(6)) bus ();

  alu_uart_ctrl #(
    .N_BITS      (8),
    .N_OP        (6),
    .TIMEOUT_CYC (16)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference signed-build ALU; also serves as the ALU seen by the DUT.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    logic [7:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SRA:  r = $signed(a) >>> b;
      OP_SRL:  r = a >> b;
      OP_NOR:  r = ~(a | b);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_comb bus.i_alu_result = alu_model(bus.o_dato_A, bus.o_dato_B, bus.o_operacion);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] d);
    @(negedge clk);
    bus.i_rx_done = 1'b1;
    bus.i_rx_data = d;
    @(posedge clk);
    #1;
    bus.i_rx_done = 1'b0;
  endtask

  task automatic tx_done_pulse();
    @(negedge clk);
    bus.i_tx_done = 1'b1;
    @(posedge clk);
    #1;
    bus.i_tx_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_A"},     bus.o_dato_A,    0);
    check_eq({tag, "_B"},     bus.o_dato_B,    0);
    check_eq({tag, "_op"},    bus.o_operacion, 0);
    check_eq({tag, "_start"}, bus.o_tx_start,  0);
    check_eq({tag, "_txd"},   bus.o_tx_data,   0);
    check_eq({tag, "_busy"},  bus.o_busy,      0);
    check_eq({tag, "_drop"},  bus.o_drop,      0);
    check_eq({tag, "_tmo"},   bus.o_timeout,   0);
  endtask

  // One complete frame; gaps are idle cycles between bytes (<16 keeps it alive).
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int unsigned gap_ab, input int unsigned gap_bop,
                           input bit spurious_txd, input bit drop_exec, input bit drop_wait,
                           input int unsigned tx_lat);
    logic [7:0] exp;
    exp = alu_model(a, b, opb[5:0]);
    rx_byte(a);
    check_eq("busy_after_A", bus.o_busy, 1);
    if (spurious_txd && gap_ab > 0) begin
      tx_done_pulse();
      check_eq("txdone_ignored", bus.o_busy, 1);
      repeat (gap_ab - 1) step();
    end else begin
      repeat (gap_ab) step();
    end
    rx_byte(b);
    repeat (gap_bop) step();
    rx_byte(opb);
    check_eq("exec_busy",  bus.o_busy,       1);
    check_eq("exec_start", bus.o_tx_start,   0);
    check_eq("opcode",     bus.o_operacion,  {26'd0, opb[5:0]});
    if (drop_exec) rx_byte(8'($urandom));
    else step();
    check_eq("send_start", bus.o_tx_start, 1);
    check_eq("tx_data",    bus.o_tx_data,  exp);
    check_eq("dato_A",     bus.o_dato_A,   a);
    check_eq("dato_B",     bus.o_dato_B,   b);
    if (drop_exec) check_eq("drop_exec", bus.o_drop, 1);
    step();
    check_eq("start_1cyc", bus.o_tx_start, 0);
    check_eq("wtx_busy",   bus.o_busy,     1);
    check_eq("drop_clr",   bus.o_drop,     0);
    repeat (tx_lat) step();
    if (drop_wait) begin
      rx_byte(8'($urandom));
      check_eq("drop_wtx",      bus.o_drop,   1);
      check_eq("drop_wtx_busy", bus.o_busy,   1);
      step();
      check_eq("drop_wtx_1cyc", bus.o_drop,   0);
      check_eq("drop_wtx_A",    bus.o_dato_A, a);
      check_eq("drop_wtx_txd",  bus.o_tx_data, exp);
    end
    tx_done_pulse();
    check_eq("idle_busy", bus.o_busy, 0);
    check_eq("hold_txd",  bus.o_tx_data, exp);
  endtask

  logic [7:0] ops [9] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR, 8'hFF};

  initial begin
    logic [7:0] ta;
    rst_n         = 1'b0;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = '0;
    bus.i_tx_done = 1'b0;
    repeat (3) step();
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Datasheet examples
    run_frame(8'h05, 8'h03, 8'h20, 0, 0, 0, 1, 0, 0);
    run_frame(8'h03, 8'h05, 8'h22, 2, 1, 1, 0, 1, 3);
    run_frame(8'h80, 8'h02, 8'h03, 0, 0, 0, 0, 0, 1);
    run_frame(8'h80, 8'h02, 8'h02, 1, 1, 0, 0, 0, 0);
    run_frame(8'h0F, 8'hF0, 8'h27, 0, 0, 0, 0, 1, 2);
    run_frame(8'h12, 8'h34, 8'hFF, 0, 0, 0, 0, 0, 0);

    // Timeout after A only: 16 idle cycles
    ta = 8'h5A;
    rx_byte(ta);
    for (int unsigned i = 1; i <= 15; i++) begin
      step();
      if (i == 15) begin
        check_eq("tmo_busy15", bus.o_busy,    1);
        check_eq("tmo_pulse15", bus.o_timeout, 0);
      end
    end
    step();
    check_eq("tmo_busy",  bus.o_busy,    0);
    check_eq("tmo_pulse", bus.o_timeout, 1);
    check_eq("tmo_holdA", bus.o_dato_A,  ta);
    step();
    check_eq("tmo_1cyc",  bus.o_timeout, 0);
    run_frame(8'hC3, 8'h11, 8'h20, 0, 0, 0, 0, 0, 0);

    // Byte arriving in the would-be expiry cycle is accepted
    run_frame(8'h21, 8'h42, 8'h26, 15, 15, 0, 0, 0, 0);
    check_eq("rxwins_notmo", bus.o_timeout, 0);

    // Asynchronous reset mid-WAIT_OP
    rx_byte(8'h77);
    rx_byte(8'h66);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_frame(8'h09, 8'h07, 8'h20, 0, 0, 0, 0, 0, 0);

    // Randomized frames
    for (int unsigned k = 0; k < 25; k++) begin
      logic [7:0] ra, rb, rop;
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      rop = ($urandom_range(0, 4) == 0) ? 8'($urandom) : ops[$urandom_range(0, 8)];
      run_frame(ra, rb, rop, $urandom_range(0, 15), $urandom_range(0, 15),
                1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
